// File: rtl/xpb_pkg.sv
// Shared constants and FSM state encoding for the XPB reduction sequencer.
// Module parameter defaults are taken from here so integrators see one source of truth.
package xpb_pkg;

    localparam int XPB_WORD_LEN   = 1024;
    localparam int XPB_CHUNK_BITS = 5;
    localparam int XPB_NUM_CHUNKS = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        DRAIN,
        DONE
    } xpb_state_t;

endpackage

// File: rtl/xpb_reduce_seq.sv
// Issues one upper-word chunk per cycle to the XPB bank and accumulates the returned multiples onto base_acc.
// Latency: result_valid NUM_CHUNKS+2 cycles after accept; result held until result_ready; no new job accepted outside IDLE.
module xpb_reduce_seq
    import xpb_pkg::*;
#(
    parameter int WORD_LEN   = XPB_WORD_LEN,
    parameter int CHUNK_BITS = XPB_CHUNK_BITS,
    parameter int NUM_CHUNKS = XPB_NUM_CHUNKS,
    parameter int IDX_W      = $clog2(XPB_NUM_CHUNKS)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start_valid,
    output logic                                       start_ready,
    input  logic [NUM_CHUNKS*CHUNK_BITS-1:0]           upper_word,
    input  logic [WORD_LEN-1:0]                        base_acc,
    output logic                                       lut_en,
    output logic [IDX_W-1:0]                           lut_chunk_idx,
    output logic [CHUNK_BITS-1:0]                      lut_data,
    input  logic [WORD_LEN-1:0]                        lut_value,
    output logic                                       result_valid,
    input  logic                                       result_ready,
    output logic [WORD_LEN+$clog2(NUM_CHUNKS+1)-1:0]   result,
    output logic                                       busy
);

    localparam int ACC_BITS = WORD_LEN + $clog2(NUM_CHUNKS + 1);
    localparam int UW_BITS  = NUM_CHUNKS * CHUNK_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    xpb_state_t          state;
    xpb_state_t          state_nxt;
    logic [IDX_W-1:0]    idx;
    logic                pend;
    logic [UW_BITS-1:0]  upper_q;
    logic [ACC_BITS-1:0] acc;
    logic [ACC_BITS-1:0] acc_sum;
    logic [ACC_BITS-1:0] result_q;
    logic                accept;

    assign accept = (state == IDLE) && start_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start_ready  = 1'b0;
        lut_en       = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                lut_en = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // lut_value belongs to the lookup issued one cycle earlier, hence gated by pend.
    assign acc_sum = acc + (pend ? {{(ACC_BITS-WORD_LEN){1'b0}}, lut_value} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            pend     <= 1'b0;
            upper_q  <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            pend <= (state == LOOKUP);
            if (accept) begin
                upper_q <= upper_word;
                acc     <= {{(ACC_BITS-WORD_LEN){1'b0}}, base_acc};
                idx     <= '0;
            end else begin
                if (pend) begin
                    acc <= acc_sum;
                end
                if ((state == LOOKUP) && (idx != LAST_IDX)) begin
                    idx <= idx + 1'b1;
                end
            end
            if (state == DRAIN) begin
                result_q <= acc_sum;
            end
        end
    end

    assign lut_chunk_idx = idx;
    assign lut_data      = upper_q[idx*CHUNK_BITS +: CHUNK_BITS];
    assign result        = result_q;

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Scoreboard bench for xpb_reduce_seq with a registered lookup model (idx+1)*data.
`timescale 1ns/1ps
module tb_xpb_reduce_seq;
    import xpb_pkg::*;

    localparam int WORD_LEN   = XPB_WORD_LEN;
    localparam int CHUNK_BITS = XPB_CHUNK_BITS;
    localparam int NUM_CHUNKS = XPB_NUM_CHUNKS;
    localparam int IDX_W      = $clog2(NUM_CHUNKS);
    localparam int ACC_BITS   = WORD_LEN + $clog2(NUM_CHUNKS + 1);
    localparam int UW_BITS    = NUM_CHUNKS * CHUNK_BITS;
    localparam logic [WORD_LEN-1:0] JUNK = {(WORD_LEN/32){32'hDEADBEEF}};

    logic                  clk;
    logic                  rst_n;
    logic                  start_valid;
    logic                  start_ready;
    logic [UW_BITS-1:0]    upper_word;
    logic [WORD_LEN-1:0]   base_acc;
    logic                  lut_en;
    logic [IDX_W-1:0]      lut_chunk_idx;
    logic [CHUNK_BITS-1:0] lut_data;
    logic [WORD_LEN-1:0]   lut_value;
    logic                  result_valid;
    logic                  result_ready;
    logic [ACC_BITS-1:0]   result;
    logic                  busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    logic all_ones_mode = 1'b0;
    logic [ACC_BITS-1:0] exp_q[$];

    xpb_reduce_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .upper_word    (upper_word),
        .base_acc      (base_acc),
        .lut_en        (lut_en),
        .lut_chunk_idx (lut_chunk_idx),
        .lut_data      (lut_data),
        .lut_value     (lut_value),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result        (result),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Junk outside the valid slot so a DUT that ignores pend gets caught.
    always @(posedge clk) begin
        if (lut_en)
            lut_value <= all_ones_mode ? {WORD_LEN{1'b1}}
                                       : WORD_LEN'((int'(lut_chunk_idx) + 1) * int'(lut_data));
        else
            lut_value <= JUNK;
    end

    function automatic logic [ACC_BITS-1:0] model(input logic [UW_BITS-1:0] uw,
                                                  input logic [WORD_LEN-1:0] base,
                                                  input logic ones);
        logic [ACC_BITS-1:0]   s;
        logic [CHUNK_BITS-1:0] c;
        s = ACC_BITS'(base);
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            c = uw[i*CHUNK_BITS +: CHUNK_BITS];
            if (ones) s = s + ACC_BITS'({WORD_LEN{1'b1}});
            else      s = s + ACC_BITS'((i + 1) * int'(c));
        end
        return s;
    endfunction

    // Runs one job with result_ready high; called at a negedge in IDLE, returns at the negedge after the handshake.
    task automatic do_job(input logic [UW_BITS-1:0] uw, input logic [WORD_LEN-1:0] base,
                          output logic [ACC_BITS-1:0] res, output int lat, output int pulses,
                          output bit seq_ok, output bit data_ok, output bit timed_out,
                          output int acc_cyc);
        seq_ok = 1; data_ok = 1; pulses = 0; lat = 0; timed_out = 0; res = '0;
        upper_word   = uw;
        base_acc     = base;
        start_valid  = 1'b1;
        result_ready = 1'b1;
        acc_cyc      = cyc;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        lat = 1;
        while (!result_valid && lat < 40) begin
            if (lut_en) begin
                if (pulses < NUM_CHUNKS) begin
                    if (lut_chunk_idx != IDX_W'(pulses)) seq_ok = 0;
                    if (lut_data != uw[pulses*CHUNK_BITS +: CHUNK_BITS]) data_ok = 0;
                end
                pulses++;
            end
            @(negedge clk);
            lat++;
        end
        timed_out = !result_valid;
        res = result;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
        upper_word = '0; base_acc = '0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({start_ready, lut_en, result_valid, busy} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rdy/en/vld/busy=%b want 1000", {start_ready, lut_en, result_valid, busy});
        end
        tests_run++;
        if (result !== '0) begin
            tests_failed++;
            $display("FAIL reset_result: got lo=%h want 0", result[63:0]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_chunks();
        logic [ACC_BITS-1:0] res, exp;
        int lat, pulses, ac;
        bit sok, dok, to;
        exp_q.push_back(model('0, WORD_LEN'(16'h1234), 1'b0));
        do_job('0, WORD_LEN'(16'h1234), res, lat, pulses, sok, dok, to, ac);
        exp = exp_q.pop_front();
        tests_run++;
        if (to !== 1'b0 || res !== exp) begin
            tests_failed++;
            $display("FAIL zero_result: got lo=%h timeout=%0d want lo=%h", res[63:0], to, exp[63:0]);
        end
        tests_run++;
        if (lat != 10) begin
            tests_failed++;
            $display("FAIL zero_latency: got %0d want 10", lat);
        end
        tests_run++;
        if (pulses != NUM_CHUNKS || !dok) begin
            tests_failed++;
            $display("FAIL zero_pulses: got pulses=%0d data_ok=%0d want %0d,1", pulses, dok, NUM_CHUNKS);
        end
    endtask

    task automatic test_max_chunks();
        logic [ACC_BITS-1:0] res, exp;
        int lat, pulses, ac;
        bit sok, dok, to;
        exp_q.push_back(model({UW_BITS{1'b1}}, '0, 1'b0));
        do_job({UW_BITS{1'b1}}, '0, res, lat, pulses, sok, dok, to, ac);
        exp = exp_q.pop_front();
        tests_run++;
        if (to !== 1'b0 || res !== exp || res !== ACC_BITS'(1116)) begin
            tests_failed++;
            $display("FAIL max_result: got lo=%h want lo=%h (0x45c)", res[63:0], exp[63:0]);
        end
        tests_run++;
        if (!sok || !dok || pulses != NUM_CHUNKS) begin
            tests_failed++;
            $display("FAIL max_idx_seq: got seq_ok=%0d data_ok=%0d pulses=%0d want 1,1,%0d", sok, dok, pulses, NUM_CHUNKS);
        end
    endtask

    task automatic test_no_wrap();
        logic [ACC_BITS-1:0] res, exp;
        int lat, pulses, ac;
        bit sok, dok, to;
        all_ones_mode = 1'b1;
        exp_q.push_back(model('0, {WORD_LEN{1'b1}}, 1'b1));
        do_job('0, {WORD_LEN{1'b1}}, res, lat, pulses, sok, dok, to, ac);
        all_ones_mode = 1'b0;
        exp = exp_q.pop_front();
        tests_run++;
        if (to !== 1'b0 || res !== exp) begin
            tests_failed++;
            $display("FAIL nowrap_result: got hi=%h lo=%h want hi=%h lo=%h", res[ACC_BITS-1 -: 64], res[63:0], exp[ACC_BITS-1 -: 64], exp[63:0]);
        end
        // 9*(2^1024-1) = 8*2^1024 + (2^1024-9)
        tests_run++;
        if (res[ACC_BITS-1 -: 4] !== 4'h8 || res[63:0] !== 64'hFFFF_FFFF_FFFF_FFF7) begin
            tests_failed++;
            $display("FAIL nowrap_top: got top=%h lo=%h want top=8 lo=fffffffffffffff7", res[ACC_BITS-1 -: 4], res[63:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [UW_BITS-1:0]  uw;
        logic [WORD_LEN-1:0] base;
        logic [ACC_BITS-1:0] held, exp;
        bit stable_ok, rdy_ok, en_ok;
        int n;
        uw   = UW_BITS'(40'h12_3456_789A);
        base = WORD_LEN'(32'h0BAD_F00D);
        exp_q.push_back(model(uw, base, 1'b0));
        upper_word = uw; base_acc = base; start_valid = 1'b1; result_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!result_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!result_valid) begin
            tests_failed++;
            $display("FAIL bp_timeout: got result_valid=0 want 1 within 40 cycles");
        end
        held = result;
        stable_ok = 1; rdy_ok = 1; en_ok = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result !== held || result_valid !== 1'b1) stable_ok = 0;
            if (start_ready !== 1'b0) rdy_ok = 0;
            if (lut_en !== 1'b0) en_ok = 0;
        end
        exp = exp_q.pop_front();
        tests_run++;
        if (held !== exp || !stable_ok) begin
            tests_failed++;
            $display("FAIL bp_result: got lo=%h stable=%0d want lo=%h stable=1", held[63:0], stable_ok, exp[63:0]);
        end
        tests_run++;
        if (!rdy_ok || !en_ok) begin
            tests_failed++;
            $display("FAIL bp_blocked: got rdy_low=%0d no_lut=%0d want 1,1", rdy_ok, en_ok);
        end
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_idle_after_hs: got busy=%b rdy=%b vld=%b want 0,1,0", busy, start_ready, result_valid);
        end
        exp_q.push_back(model(uw, base, 1'b0));
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        tests_run++;
        if (lut_en !== 1'b1 || lut_chunk_idx !== '0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_next_accept: got en=%b idx=%0d busy=%b want 1,0,1", lut_en, lut_chunk_idx, busy);
        end
        n = 0;
        while (!result_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp = exp_q.pop_front();
        tests_run++;
        if (!result_valid || result !== exp) begin
            tests_failed++;
            $display("FAIL bp_second_result: got vld=%b lo=%h want 1 lo=%h", result_valid, result[63:0], exp[63:0]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        logic [UW_BITS-1:0]  uw;
        logic [ACC_BITS-1:0] res, exp;
        int lat, pulses, ac;
        bit sok, dok, to;
        upper_word = {UW_BITS{1'b1}}; base_acc = WORD_LEN'(32'h5555_AAAA);
        start_valid = 1'b1; result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({start_ready, lut_en, result_valid, busy} !== 4'b1000 || result !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got rdy/en/vld/busy=%b res_lo=%h want 1000 0",
                     {start_ready, lut_en, result_valid, busy}, result[63:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        uw = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) uw = uw | (UW_BITS'(1) << (i * CHUNK_BITS));
        exp_q.push_back(model(uw, '0, 1'b0));
        do_job(uw, '0, res, lat, pulses, sok, dok, to, ac);
        exp = exp_q.pop_front();
        tests_run++;
        if (to !== 1'b0 || res !== exp || res !== ACC_BITS'(36)) begin
            tests_failed++;
            $display("FAIL midrst_next_job: got lo=%h want lo=%h (36)", res[63:0], exp[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [UW_BITS-1:0]  uw;
        logic [WORD_LEN-1:0] base;
        logic [ACC_BITS-1:0] res, exp;
        int lat, pulses, ac, prev_ac;
        bit sok, dok, to;
        prev_ac = -1;
        for (int j = 0; j < 4; j++) begin
            uw = UW_BITS'({$urandom(), $urandom()});
            for (int w = 0; w < WORD_LEN / 32; w++) base[w*32 +: 32] = $urandom();
            exp_q.push_back(model(uw, base, 1'b0));
            do_job(uw, base, res, lat, pulses, sok, dok, to, ac);
            exp = exp_q.pop_front();
            tests_run++;
            if (to !== 1'b0 || res !== exp || !sok || !dok) begin
                tests_failed++;
                $display("FAIL b2b_result[%0d]: got lo=%h seq=%0d data=%0d want lo=%h", j, res[63:0], sok, dok, exp[63:0]);
            end
            if (prev_ac >= 0) begin
                tests_run++;
                if (ac - prev_ac != NUM_CHUNKS + 3) begin
                    tests_failed++;
                    $display("FAIL b2b_spacing[%0d]: got %0d want %0d", j, ac - prev_ac, NUM_CHUNKS + 3);
                end
            end
            prev_ac = ac;
        end
    endtask

    initial begin
        test_reset();
        test_zero_chunks();
        test_max_chunks();
        test_no_wrap();
        test_backpressure();
        test_reset_mid_job();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
